// File: rtl/xoodoo_arbiter.sv
// xoodoo_arbiter: shares one XOODOO permutation core between two requesters.
// Round-robin grant, one 384-bit job at a time, registered valid/ready
// response per requester, and a RUN-cycle timeout that returns an all-zero
// state flagged with rsp_err if the core never reports done.
module xoodoo_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [383:0] req_state0,
    input  logic [383:0] req_state1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [383:0] rsp_state,
    output logic         rsp_err,
    output logic         core_enable,
    output logic [383:0] core_state_in,
    input  logic [383:0] core_state_out,
    input  logic         core_done
);

    // Counter value seen on the last RUN cycle before the job is aborted.
    localparam logic [CNT_W-1:0] LAST_RUN_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         req_ready_q, req_ready_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [383:0]       rsp_state_q, rsp_state_d;
    logic               rsp_err_q, rsp_err_d;
    logic               core_enable_q, core_enable_d;
    logic [383:0]       core_state_in_q, core_state_in_d;
    logic               grant;

    // Round-robin pick: a lone requester always wins; on a tie the
    // requester that was not granted last time wins.
    function automatic logic pick_grant(input logic [1:0] valid, input logic last);
        logic g;
        case (valid)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            default: g = ~last;
        endcase
        return g;
    endfunction

    // Next-state and next-output logic for the job FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        cnt_d           = cnt_q;
        req_ready_d     = 2'b00;
        rsp_valid_d     = rsp_valid_q;
        rsp_state_d     = rsp_state_q;
        rsp_err_d       = rsp_err_q;
        core_enable_d   = core_enable_q;
        core_state_in_d = core_state_in_q;
        grant           = pick_grant(req_valid, last_grant_q);

        unique case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready_d     = grant ? 2'b10 : 2'b01;
                    core_state_in_d = grant ? req_state1 : req_state0;
                    owner_d         = grant;
                    last_grant_d    = grant;
                    cnt_d           = '0;
                    core_enable_d   = 1'b1;
                    state_d         = RUN;
                end
            end

            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done on the timeout cycle still counts as success.
                if (core_done) begin
                    rsp_state_d   = core_state_out;
                    rsp_err_d     = 1'b0;
                    core_enable_d = 1'b0;
                    rsp_valid_d   = owner_q ? 2'b10 : 2'b01;
                    state_d       = RESP;
                end else if (cnt_q == LAST_RUN_CNT) begin
                    rsp_state_d   = '0;
                    rsp_err_d     = 1'b1;
                    core_enable_d = 1'b0;
                    rsp_valid_d   = owner_q ? 2'b10 : 2'b01;
                    state_d       = RESP;
                end
            end

            RESP: begin
                // Only the owner's ready matters; the other bit is ignored.
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = GAP;
                end
            end

            GAP: begin
                // One dead cycle with the core disabled so it re-arms;
                // a lingering core_done is ignored here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the wide data registers are reset as well, because their
            // zero reset value is directly visible on the output ports.
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            cnt_q           <= '0;
            req_ready_q     <= 2'b00;
            rsp_valid_q     <= 2'b00;
            rsp_state_q     <= '0;
            rsp_err_q       <= 1'b0;
            core_enable_q   <= 1'b0;
            core_state_in_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_state_q     <= rsp_state_d;
            rsp_err_q       <= rsp_err_d;
            core_enable_q   <= core_enable_d;
            core_state_in_q <= core_state_in_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_state     = rsp_state_q;
    assign rsp_err       = rsp_err_q;
    assign core_enable   = core_enable_q;
    assign core_state_in = core_state_in_q;

endmodule
